// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB transmit packet sequencer.
// Used by the sequencer top and its cycle counters.
package usb_tx_pkg;

   typedef enum logic [1:0] {
      PKT_DATA      = 2'b00,
      PKT_ZLP       = 2'b01,
      PKT_HANDSHAKE = 2'b10,
      PKT_INVALID   = 2'b11
   } pkt_type_t;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SYNC    = 3'd1,
      ST_PID     = 3'd2,
      ST_DATA    = 3'd3,
      ST_CRC16   = 3'd4,
      ST_EOP_SE0 = 3'd5,
      ST_EOP_J   = 3'd6
   } tx_state_t;

   // EOP line-state durations, in USB bit periods
   localparam int EOP_SE0_BITS = 2;
   localparam int EOP_J_BITS   = 1;

   function automatic logic is_field(input tx_state_t s);
      return (s == ST_SYNC) || (s == ST_PID) || (s == ST_DATA) || (s == ST_CRC16);
   endfunction

endpackage

// File: rtl/usb_tx_cycle_counter.sv
// Up-counter with synchronous clear/enable, saturating at all-ones.
// tc is a registered-count compare against a runtime terminal value; no backpressure.
module usb_tx_cycle_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             clr,
   input  logic             en,
   input  logic [WIDTH-1:0] terminal,
   output logic             tc
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (en && (count_q != {WIDTH{1'b1}})) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign tc = (count_q == terminal);

endmodule

// File: rtl/usb_tx_controller.sv
// Device-side USB transmit packet sequencer: SYNC/PID/DATA/CRC16 strobes, EOP, watchdog.
// All outputs registered; fields advance one cycle after the timer's bits_transmitted pulse.
module usb_tx_controller
   import usb_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT   = 8,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       tx_start,
   input  logic [1:0] pkt_type,
   input  logic       tx_abort,
   input  logic       sync_bits_transmitted,
   input  logic       pid_bits_transmitted,
   input  logic       data_bits_transmitted,
   input  logic       crc16_bits_transmitted,
   output logic       sync_transmitting,
   output logic       pid_transmitting,
   output logic       data_transmitting,
   output logic       crc16_transmitting,
   output logic       eop_se0,
   output logic       eop_j,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       tx_error,
   output logic       tx_aborted
);

   localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam int EOP_W = $clog2(2 * CLKS_PER_BIT);

   // The watchdog fires on the cycle the count would reach TIMEOUT_CYCLES
   localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
   localparam logic [EOP_W-1:0] SE0_LAST = EOP_W'(EOP_SE0_BITS * CLKS_PER_BIT - 1);
   localparam logic [EOP_W-1:0] J_LAST   = EOP_W'(EOP_J_BITS * CLKS_PER_BIT - 1);

   tx_state_t state_q, state_d;
   pkt_type_t pkt_type_q, pkt_type_d;
   logic sync_transmitting_q, sync_transmitting_d;
   logic pid_transmitting_q, pid_transmitting_d;
   logic data_transmitting_q, data_transmitting_d;
   logic crc16_transmitting_q, crc16_transmitting_d;
   logic eop_se0_q, eop_se0_d;
   logic eop_j_q, eop_j_d;
   logic tx_busy_q, tx_busy_d;
   logic tx_done_q, tx_done_d;
   logic tx_error_q, tx_error_d;
   logic tx_aborted_q, tx_aborted_d;

   logic in_field;
   logic in_eop;
   logic field_done;
   logic state_change;
   logic wd_tc;
   logic eop_tc;
   logic [EOP_W-1:0] eop_terminal;

   assign in_field     = is_field(state_q);
   assign in_eop       = (state_q == ST_EOP_SE0) || (state_q == ST_EOP_J);
   assign state_change = (state_d != state_q);
   assign eop_terminal = (state_q == ST_EOP_SE0) ? SE0_LAST : J_LAST;

   assign field_done = ((state_q == ST_SYNC)  && sync_bits_transmitted)
                    || ((state_q == ST_PID)   && pid_bits_transmitted)
                    || ((state_q == ST_DATA)  && data_bits_transmitted)
                    || ((state_q == ST_CRC16) && crc16_bits_transmitted);

   usb_tx_cycle_counter #(.WIDTH(WD_W)) u_watchdog (
      .clk      (clk),
      .n_rst    (n_rst),
      .clr      (state_change),
      .en       (in_field),
      .terminal (WD_LAST),
      .tc       (wd_tc)
   );

   usb_tx_cycle_counter #(.WIDTH(EOP_W)) u_eop_timer (
      .clk      (clk),
      .n_rst    (n_rst),
      .clr      (state_change),
      .en       (in_eop),
      .terminal (eop_terminal),
      .tc       (eop_tc)
   );

   always_comb begin
      state_d      = state_q;
      pkt_type_d   = pkt_type_q;
      tx_aborted_d = tx_aborted_q;
      tx_error_d   = 1'b0;
      tx_done_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (tx_start) begin
               if (pkt_type_t'(pkt_type) == PKT_INVALID) begin
                  tx_error_d = 1'b1;
               end else begin
                  pkt_type_d   = pkt_type_t'(pkt_type);
                  tx_aborted_d = 1'b0;
                  state_d      = ST_SYNC;
               end
            end
         end
         ST_SYNC:  if (field_done) state_d = ST_PID;
         ST_PID: begin
            if (field_done) begin
               case (pkt_type_q)
                  PKT_DATA: state_d = ST_DATA;
                  PKT_ZLP:  state_d = ST_CRC16;
                  default:  state_d = ST_EOP_SE0;
               endcase
            end
         end
         ST_DATA:  if (field_done) state_d = ST_CRC16;
         ST_CRC16: if (field_done) state_d = ST_EOP_SE0;
         ST_EOP_SE0: if (eop_tc) state_d = ST_EOP_J;
         ST_EOP_J: begin
            if (eop_tc) begin
               state_d   = ST_IDLE;
               tx_done_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Abort outranks a same-cycle field advance, which outranks the watchdog
      if (in_field) begin
         if (tx_abort) begin
            state_d      = ST_EOP_SE0;
            tx_aborted_d = 1'b1;
         end else if (!field_done && wd_tc) begin
            state_d      = ST_EOP_SE0;
            tx_error_d   = 1'b1;
            tx_aborted_d = 1'b1;
         end
      end

      sync_transmitting_d  = (state_d == ST_SYNC);
      pid_transmitting_d   = (state_d == ST_PID);
      data_transmitting_d  = (state_d == ST_DATA);
      crc16_transmitting_d = (state_d == ST_CRC16);
      eop_se0_d            = (state_d == ST_EOP_SE0);
      eop_j_d              = (state_d == ST_EOP_J);
      tx_busy_d            = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_q              <= ST_IDLE;
         pkt_type_q           <= PKT_DATA;
         sync_transmitting_q  <= 1'b0;
         pid_transmitting_q   <= 1'b0;
         data_transmitting_q  <= 1'b0;
         crc16_transmitting_q <= 1'b0;
         eop_se0_q            <= 1'b0;
         eop_j_q              <= 1'b0;
         tx_busy_q            <= 1'b0;
         tx_done_q            <= 1'b0;
         tx_error_q           <= 1'b0;
         tx_aborted_q         <= 1'b0;
      end else begin
         state_q              <= state_d;
         pkt_type_q           <= pkt_type_d;
         sync_transmitting_q  <= sync_transmitting_d;
         pid_transmitting_q   <= pid_transmitting_d;
         data_transmitting_q  <= data_transmitting_d;
         crc16_transmitting_q <= crc16_transmitting_d;
         eop_se0_q            <= eop_se0_d;
         eop_j_q              <= eop_j_d;
         tx_busy_q            <= tx_busy_d;
         tx_done_q            <= tx_done_d;
         tx_error_q           <= tx_error_d;
         tx_aborted_q         <= tx_aborted_d;
      end
   end

   assign sync_transmitting  = sync_transmitting_q;
   assign pid_transmitting   = pid_transmitting_q;
   assign data_transmitting  = data_transmitting_q;
   assign crc16_transmitting = crc16_transmitting_q;
   assign eop_se0            = eop_se0_q;
   assign eop_j              = eop_j_q;
   assign tx_busy            = tx_busy_q;
   assign tx_done            = tx_done_q;
   assign tx_error           = tx_error_q;
   assign tx_aborted         = tx_aborted_q;

endmodule

// File: tb/tb_usb_tx_controller.sv
// Bench for usb_tx_controller: per-cycle expected traces built from packet-level rules,
// with randomized field timing, aborts, timeouts and ignored-input noise.
module tb_usb_tx_controller;

   localparam int CPB     = 8;
   localparam int TIMEOUT = 1024;
   localparam int SE0_LEN = 2 * CPB;
   localparam int J_LEN   = CPB;

   logic clk, n_rst, tx_start, tx_abort;
   logic [1:0] pkt_type;
   logic sync_b, pid_b, data_b, crc_b;
   logic sync_transmitting, pid_transmitting, data_transmitting, crc16_transmitting;
   logic eop_se0, eop_j, tx_busy, tx_done, tx_error, tx_aborted;

   typedef struct packed {
      logic [3:0] strobe;   // [0]=SYNC [1]=PID [2]=DATA [3]=CRC16
      logic se0;
      logic j;
      logic busy;
      logic done;
      logic err;
      logic aborted;
   } out_t;

   typedef struct packed {
      logic       start;
      logic [1:0] ty;
      logic       abort;
      logic [3:0] bits;
   } drv_t;

   out_t exp_q[$];
   drv_t drv_q[$];
   logic m_aborted;
   int   errors = 0;
   int   checks = 0;

   usb_tx_controller #(.CLKS_PER_BIT(CPB), .TIMEOUT_CYCLES(TIMEOUT)) dut (
      .clk                    (clk),
      .n_rst                  (n_rst),
      .tx_start               (tx_start),
      .pkt_type               (pkt_type),
      .tx_abort               (tx_abort),
      .sync_bits_transmitted  (sync_b),
      .pid_bits_transmitted   (pid_b),
      .data_bits_transmitted  (data_b),
      .crc16_bits_transmitted (crc_b),
      .sync_transmitting      (sync_transmitting),
      .pid_transmitting       (pid_transmitting),
      .data_transmitting      (data_transmitting),
      .crc16_transmitting     (crc16_transmitting),
      .eop_se0                (eop_se0),
      .eop_j                  (eop_j),
      .tx_busy                (tx_busy),
      .tx_done                (tx_done),
      .tx_error               (tx_error),
      .tx_aborted             (tx_aborted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL global_timeout: simulation limit reached, got running want finished");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic out_t sample();
      out_t o;
      o.strobe  = {crc16_transmitting, data_transmitting, pid_transmitting, sync_transmitting};
      o.se0     = eop_se0;
      o.j       = eop_j;
      o.busy    = tx_busy;
      o.done    = tx_done;
      o.err     = tx_error;
      o.aborted = tx_aborted;
      return o;
   endfunction

   task automatic apply(input drv_t d);
      tx_start = d.start;
      pkt_type = d.ty;
      tx_abort = d.abort;
      sync_b   = d.bits[0];
      pid_b    = d.bits[1];
      data_b   = d.bits[2];
      crc_b    = d.bits[3];
   endtask

   // Field order for a packet type: 0 SYNC, 1 PID, 2 DATA, 3 CRC16
   function automatic int n_fields(input int ty);
      return (ty == 0) ? 4 : (ty == 1) ? 3 : 2;
   endfunction

   function automatic int field_at(input int ty, input int k);
      if (k < 2) return k;
      if (ty == 0) return k;
      return 3;
   endfunction

   // cur: field index in progress, -1 for EOP, -2 for idle (no start noise)
   function automatic drv_t noise(input int cur, input bit noisy, input bit hammer);
      drv_t d = '0;
      if (noisy) begin
         for (int b = 0; b < 4; b++)
            if (b != cur && $urandom_range(7) == 0) d.bits[b] = 1'b1;
         if (cur < 0 && $urandom_range(5) == 0) d.abort = 1'b1;
         if (cur != -2 && $urandom_range(5) == 0) begin
            d.start = 1'b1;
            d.ty    = 2'($urandom_range(3));
         end
      end
      if (hammer && cur >= 0) begin
         d.start = 1'b1;
         d.ty    = 2'($urandom_range(3));
      end
      return d;
   endfunction

   // pa[f]: cycle within field f at which its bits_transmitted pulse comes.
   // ab_f/ab_a: abort in field ab_f at that age. to_f: field whose pulse is withheld.
   task automatic build_trace(input int ty, input int pa[4], input int ab_f, input int ab_a,
                              input int to_f, input bit noisy, input bit hammer);
      out_t e;
      drv_t d;
      int   kind = 0;   // 0 normal, 1 abort, 2 timeout
      int   len, f;
      exp_q.delete();
      drv_q.delete();
      e = '0;
      e.aborted = m_aborted;
      d = noise(-2, noisy, 1'b0);
      d.start = 1'b1;
      d.ty = 2'(ty);
      exp_q.push_back(e);
      drv_q.push_back(d);
      for (int k = 0; k < n_fields(ty); k++) begin
         f = field_at(ty, k);
         if (f == to_f)      len = TIMEOUT;
         else if (f == ab_f) len = ab_a + 1;
         else                len = pa[f] + 1;
         for (int a = 0; a < len; a++) begin
            e = '0;
            e.strobe[f] = 1'b1;
            e.busy = 1'b1;
            d = noise(f, noisy, hammer);
            if (f != to_f && a == pa[f]) d.bits[f] = 1'b1;
            if (f == ab_f && a == ab_a) d.abort = 1'b1;
            exp_q.push_back(e);
            drv_q.push_back(d);
         end
         if (f == ab_f) begin kind = 1; break; end
         if (f == to_f) begin kind = 2; break; end
      end
      m_aborted = (kind != 0);
      for (int a = 0; a < SE0_LEN + J_LEN; a++) begin
         e = '0;
         e.se0 = (a < SE0_LEN);
         e.j = (a >= SE0_LEN);
         e.busy = 1'b1;
         e.err = (kind == 2) && (a == 0);
         e.aborted = m_aborted;
         exp_q.push_back(e);
         drv_q.push_back(noise(-1, noisy, 1'b0));
      end
      for (int a = 0; a < 2; a++) begin
         e = '0;
         e.done = (a == 0);
         e.aborted = m_aborted;
         exp_q.push_back(e);
         drv_q.push_back(noise(-2, noisy, 1'b0));
      end
   endtask

   task automatic run_trace(output int bad, output out_t got, output out_t want);
      out_t o;
      bad = -1;
      got = '0;
      want = '0;
      for (int i = 0; i < exp_q.size(); i++) begin
         o = sample();
         if (o !== exp_q[i] && bad < 0) begin
            bad = i;
            got = o;
            want = exp_q[i];
         end
         apply(drv_q[i]);
         tick();
      end
      apply('0);
   endtask

   task automatic test_reset();
      out_t o;
      n_rst = 1'b0;
      apply('0);
      repeat (3) tick();
      o = sample();
      checks++;
      if (o !== out_t'(0)) begin
         errors++;
         $display("FAIL reset_outputs: got %b want %b", o, out_t'(0));
      end
      n_rst = 1'b1;
      tick();
      o = sample();
      checks++;
      if (o !== out_t'(0)) begin
         errors++;
         $display("FAIL idle_after_reset: got %b want %b", o, out_t'(0));
      end
      m_aborted = 1'b0;
   endtask

   task automatic test_data_packet();
      int pa[4];
      int bad;
      out_t g, w;
      pa = '{20, 20, 20, 20};
      build_trace(0, pa, -1, 0, -1, 1'b0, 1'b0);
      run_trace(bad, g, w);
      checks++;
      if (bad !== -1) begin
         errors++;
         $display("FAIL data_packet: cycle %0d got %b want %b", bad, g, w);
      end
   endtask

   task automatic test_zlp_handshake();
      int pa[4];
      int bad;
      out_t g, w;
      pa = '{20, 20, 20, 20};
      for (int ty = 1; ty <= 2; ty++) begin
         build_trace(ty, pa, -1, 0, -1, 1'b0, 1'b0);
         run_trace(bad, g, w);
         checks++;
         if (bad !== -1) begin
            errors++;
            $display("FAIL type%0d_packet: cycle %0d got %b want %b", ty, bad, g, w);
         end
      end
   endtask

   task automatic test_timeout();
      int pa[4];
      int bad;
      out_t g, w;
      pa = '{20, 20, 0, 20};
      build_trace(0, pa, -1, 0, 2, 1'b0, 1'b0);
      run_trace(bad, g, w);
      checks++;
      if (bad !== -1) begin
         errors++;
         $display("FAIL timeout_packet: cycle %0d got %b want %b", bad, g, w);
      end
      // next accepted start clears the sticky aborted status
      pa = '{3, 3, 3, 3};
      build_trace(1, pa, -1, 0, -1, 1'b0, 1'b0);
      run_trace(bad, g, w);
      checks++;
      if (bad !== -1) begin
         errors++;
         $display("FAIL aborted_clear: cycle %0d got %b want %b", bad, g, w);
      end
   endtask

   task automatic test_abort_priority();
      int pa[4];
      int bad;
      out_t g, w;
      pa = '{20, 20, 20, 20};
      build_trace(0, pa, 1, 20, -1, 1'b0, 1'b0);
      run_trace(bad, g, w);
      checks++;
      if (bad !== -1) begin
         errors++;
         $display("FAIL abort_priority: cycle %0d got %b want %b", bad, g, w);
      end
   endtask

   task automatic test_invalid_and_busy_start();
      out_t o, e;
      int pa[4];
      int bad;
      out_t g, w;
      tx_start = 1'b1;
      pkt_type = 2'b11;
      tick();
      apply('0);
      o = sample();
      e = '0;
      e.err = 1'b1;
      e.aborted = m_aborted;
      checks++;
      if (o !== e) begin
         errors++;
         $display("FAIL invalid_type_error: got %b want %b", o, e);
      end
      tick();
      o = sample();
      e.err = 1'b0;
      checks++;
      if (o !== e) begin
         errors++;
         $display("FAIL invalid_type_idle: got %b want %b", o, e);
      end
      pa = '{5, 6, 20, 7};
      build_trace(0, pa, -1, 0, -1, 1'b0, 1'b1);
      run_trace(bad, g, w);
      checks++;
      if (bad !== -1) begin
         errors++;
         $display("FAIL busy_start_ignored: cycle %0d got %b want %b", bad, g, w);
      end
   endtask

   task automatic test_reset_mid_data();
      out_t o, e;
      int pa[4];
      int bad, seen;
      out_t g, w;
      tx_start = 1'b1;
      pkt_type = 2'b00;
      tick();
      tx_start = 1'b0;
      repeat (2) tick();
      sync_b = 1'b1;
      tick();
      sync_b = 1'b0;
      tick();
      pid_b = 1'b1;
      tick();
      pid_b = 1'b0;
      repeat (3) tick();
      o = sample();
      e = '0;
      e.strobe = 4'b0100;
      e.busy = 1'b1;
      checks++;
      if (o !== e) begin
         errors++;
         $display("FAIL pre_reset_data: got %b want %b", o, e);
      end
      n_rst = 1'b0;
      tick();
      n_rst = 1'b1;
      o = sample();
      checks++;
      if (o !== out_t'(0)) begin
         errors++;
         $display("FAIL mid_reset_outputs: got %b want %b", o, out_t'(0));
      end
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (sample() !== out_t'(0)) seen++;
      end
      checks++;
      if (seen !== 0) begin
         errors++;
         $display("FAIL no_done_after_reset: got %0d active cycles want 0", seen);
      end
      m_aborted = 1'b0;
      pa = '{4, 9, 13, 2};
      build_trace(0, pa, -1, 0, -1, 1'b0, 1'b0);
      run_trace(bad, g, w);
      checks++;
      if (bad !== -1) begin
         errors++;
         $display("FAIL fresh_after_reset: cycle %0d got %b want %b", bad, g, w);
      end
   endtask

   task automatic test_random_packets();
      int pa[4];
      int ty, ab_f, ab_a, to_f, bad;
      out_t g, w;
      for (int n = 0; n < 16; n++) begin
         ty = $urandom_range(2);
         for (int f = 0; f < 4; f++) pa[f] = $urandom_range(40);
         ab_f = -1;
         ab_a = 0;
         to_f = -1;
         if (n == 5 || n == 11) begin
            to_f = field_at(ty, $urandom_range(n_fields(ty) - 1));
         end else if ($urandom_range(3) == 0) begin
            ab_f = field_at(ty, $urandom_range(n_fields(ty) - 1));
            ab_a = $urandom_range(pa[ab_f]);
         end
         build_trace(ty, pa, ab_f, ab_a, to_f, 1'b1, 1'b0);
         run_trace(bad, g, w);
         checks++;
         if (bad !== -1) begin
            errors++;
            $display("FAIL random_pkt%0d ty=%0d ab=%0d/%0d to=%0d: cycle %0d got %b want %b",
                     n, ty, ab_f, ab_a, to_f, bad, g, w);
         end
         repeat ($urandom_range(3)) tick();
      end
   endtask

   initial begin
      test_reset();
      test_data_packet();
      test_zlp_handshake();
      test_timeout();
      test_abort_priority();
      test_invalid_and_busy_start();
      test_reset_mid_data();
      test_random_packets();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/usb_tx_controller.md
Name: usb_tx_controller

Overview:
Packet-sequencing FSM for the device-side USB transmitter. It sits directly upstream of the transmit timer. It drives the one-hot per-field *_transmitting strobes that the timer consumes, and it advances on the timer's *_bits_transmitted pulses. It also generates the EOP line state (SE0 then J), a per-field watchdog, and start/done/abort/error status toward the packet-layer control.

Parameters:
CLKS_PER_BIT, 8, clk cycles per USB bit period; sets EOP duration.
TIMEOUT_CYCLES, 1024, max cycles a field may stay active without its bits_transmitted pulse.

Ports:
clk  in  1  system clock
n_rst  in  1  reset; synchronous, active-low
tx_start  in  1  request to send a packet; sampled only in IDLE
pkt_type  in  2  2'b00 DATA, 2'b01 ZLP (zero-length data), 2'b10 HANDSHAKE, 2'b11 invalid; latched with tx_start
tx_abort  in  1  abort the current packet
sync_bits_transmitted  in  1  1-cycle pulse from timer
pid_bits_transmitted  in  1  1-cycle pulse from timer
data_bits_transmitted  in  1  1-cycle pulse from timer
crc16_bits_transmitted  in  1  1-cycle pulse from timer
sync_transmitting  out  1  SYNC field active
pid_transmitting  out  1  PID field active
data_transmitting  out  1  DATA field (64 bits) active
crc16_transmitting  out  1  CRC16 field active
eop_se0  out  1  drive SE0 on the bus
eop_j  out  1  drive idle J after SE0
tx_busy  out  1  high in every state except IDLE
tx_done  out  1  1-cycle pulse when the packet, including EOP, completes
tx_error  out  1  1-cycle pulse on watchdog timeout or invalid pkt_type
tx_aborted  out  1  status: last packet ended by abort or timeout; cleared on the next accepted tx_start

Behaviour:
- Reset:
  - On a clk edge with n_rst=0, state becomes IDLE.
  - All outputs go to 0; latched type goes to DATA; watchdog and EOP counters go to 0.
- States: IDLE, SYNC, PID, DATA, CRC16, EOP_SE0, EOP_J.
- Output decode:
  - Each *_transmitting output, eop_se0 and eop_j is a Moore decode of the state register. Each is high only in its own state.
- Field sequences:
  - DATA: SYNC>PID>DATA>CRC16>EOP_SE0.
  - ZLP: SYNC>PID>CRC16>EOP_SE0.
  - HANDSHAKE: SYNC>PID>EOP_SE0.
- Start handshake:
  - In IDLE with tx_start=1 and pkt_type!=11 at edge k: latch the type, clear tx_aborted, enter SYNC. sync_transmitting is high from cycle k+1.
  - With pkt_type=11: stay in IDLE and pulse tx_error at k+1.
  - tx_start outside IDLE is ignored.
- Field advance:
  - In a field state, the matching *_bits_transmitted=1 moves the FSM to the next state on the next edge. The current strobe falls one cycle after the pulse.
  - Pulses for non-current fields are ignored.
- EOP:
  - EOP_SE0 lasts exactly 2*CLKS_PER_BIT cycles; EOP_J lasts exactly CLKS_PER_BIT cycles.
  - EOP_J then moves to IDLE. tx_done pulses in the first IDLE cycle.
  - Packet end to the next accepted start is at least 1 cycle.
- Watchdog:
  - The counter clears on every state entry and increments each cycle in SYNC, PID, DATA or CRC16.
  - On reaching TIMEOUT_CYCLES: pulse tx_error, set tx_aborted, go to EOP_SE0.
- Abort:
  - tx_abort in SYNC, PID, DATA or CRC16 sets tx_aborted and goes to EOP_SE0. No tx_error is raised.
  - tx_abort is ignored in IDLE, EOP_SE0 and EOP_J.
  - tx_done still pulses after the EOP.
- Priority, same cycle: n_rst > tx_abort > bits_transmitted advance > watchdog timeout.
- Reset mid-packet: all strobes drop on that edge and no tx_done is issued.
- Widths:
  - Watchdog counter is $clog2(TIMEOUT_CYCLES+1) bits, saturating.
  - EOP counter is $clog2(2*CLKS_PER_BIT) bits.

Decomposition:
- Shared package usb_tx_pkg contains:
  - pkt_type_t enum (DATA, ZLP, HANDSHAKE, INVALID).
  - tx_state_t enum.
  - Constants EOP_SE0_BITS=2 and EOP_J_BITS=1.
- One sub-module, usb_tx_cycle_counter: synchronous-reset up-counter with clear, enable and terminal-count compare.
  - Instantiated twice: watchdog and EOP duration.

Test Plan:
- DATA packet: tx_start, pkt_type=00; pulse each bits_transmitted 20 cycles after its field starts -> strobes in order SYNC, PID, DATA, CRC16; eop_se0 high 16 cycles, eop_j high 8 cycles; one tx_done pulse; tx_aborted=0.
- ZLP and HANDSHAKE: data_transmitting never asserts for either; crc16_transmitting never asserts for HANDSHAKE; EOP timing is 16+8 cycles in both.
- Timeout: DATA packet, withhold data_bits_transmitted -> tx_error pulses exactly 1024 cycles after DATA entry; EOP follows; tx_done pulses; tx_aborted=1 until the next start.
- Abort priority: tx_abort and pid_bits_transmitted in the same cycle -> next state EOP_SE0 (not DATA); tx_error=0; tx_aborted=1.
- Invalid and busy start: pkt_type=11 -> tx_error pulse, tx_busy stays 0; tx_start during DATA -> ignored, sequence unchanged.
- Reset mid-DATA: n_rst=0 for one edge -> all outputs 0 next cycle, no tx_done; a fresh start then completes normally.
